commit_unit: RTL and testbench
==============================

// Module: commit_unit
// PURPOSE
//  Consumer end of the ROB commit interface: retires the ROB head in order (1/cycle) and owns the
//  architectural RAT (ARAT). Frees pd_old to the free list and releases stores to the LSQ.
//  On an external flush request it pulses flush_valid to ROB/pipeline, then replays the ARAT to rename.
// PARAMETERS
//  ARCH_REGS  32      architectural registers; x0 hard-wired, never remapped
//  PHYS_W_P   PHYS_W  physical register index width
//  ROB_W_P    ROB_W   ROB index width
//  CNT_W      64      retired-instruction counter width
// PORTS
//  clk             in   1         single clock
//  rst             in   1         reset: asynchronous, active-high
//  commit_valid    in   1         ROB head retirable
//  commit_ready    out  1         head accepted this cycle (commit_fire = valid & ready)
//  commit_entry    in   rob_entry_t   head entry (uses_rd, rd_arch, pd_new, pd_old, is_store, ...)
//  commit_rob_idx  in   ROB_W_P   head index
//  free_valid      out  1         pd_old release to free list
//  free_ready      in   1         free list can accept
//  free_pd         out  PHYS_W_P  released phys reg
//  st_commit_valid out  1         store at head may drain to memory
//  st_commit_ready in   1         LSQ accepted the store release
//  st_commit_rob_idx out ROB_W_P  ROB index of released store
//  flush_req       in   1         level request (fence/CSR/debug); held until flush_ack
//  flush_ack       out  1         1-cycle pulse: request accepted
//  flush_valid     out  1         1-cycle pulse to ROB and pipeline
//  flush_rob_idx   out  ROB_W_P   index of last retired entry
//  restore_valid   out  1         ARAT replay beat to rename
//  restore_arch    out  5         arch reg of beat
//  restore_pd      out  PHYS_W_P  committed phys mapping
//  restore_done    out  1         1-cycle pulse after last beat
//  retired_cnt     out  CNT_W     instructions retired since reset
// BEHAVIOUR
//  Reset: state RUN; ARAT[i]=i; retired_cnt=0; flush_rob_idx=0; all valid/pulse outputs 0.
//  States: RUN -> FLUSH -> RESTORE -> RUN.
//  RUN: needs_free = uses_rd & rd_arch!=0. free_valid = commit_valid & needs_free;
//   st_commit_valid = commit_valid & is_store; st_commit_rob_idx = commit_rob_idx (comb).
//   commit_ready = !flush_req & (!needs_free | free_ready) & (!is_store | st_commit_ready).
//   No valid depends on a ready. free and store fire only in the commit_fire cycle, never partially.
//  commit_fire, next edge: ARAT[rd_arch]<=pd_new if needs_free; retired_cnt+=1 (wraps);
//   flush_rob_idx<=commit_rob_idx.
//  Store with uses_rd: both handshakes must be ready in the same cycle.
//  flush_req in RUN: commit_ready=0 that cycle; flush_ack=1 (comb); next state FLUSH.
//   flush_req has priority over a retirable head in that cycle.
//  FLUSH (1 cycle): flush_valid=1; commit_ready=0; next RESTORE; replay counter cleared to 1.
//  RESTORE: restore_valid=1, restore_arch=ctr, restore_pd=ARAT[ctr]; ctr 1..ARCH_REGS-1,
//   1 beat/cycle, no backpressure. After beat ARCH_REGS-1: restore_done pulses and state -> RUN.
//   Restore latency is ARCH_REGS cycles after flush_valid (31 beats + done).
//  flush_req in FLUSH/RESTORE is ignored. Nested requests are taken only on return to RUN.
//  commit_ready=0 throughout FLUSH/RESTORE. ARAT is read-only outside RUN.
//  rst mid-RESTORE: immediate return to reset state. No partial beats after deassert.
//  rd_arch==0 with uses_rd: retired and counted, no free, no ARAT write.
// STRUCTURE
//  Shared package (defines.svh): rob_entry_t (existing), commit_state_t {C_RUN,C_FLUSH,C_RESTORE},
//   ARCH_REGS constant.
//  Sub-module arch_rat: ARCH_REGS x PHYS_W_P regs; 1 write port, 2 comb read ports (dest
//   lookup/debug, replay); reset identity; x0 write suppressed.
//  Top-level holds the FSM, handshake logic, replay counter and retired_cnt.
// TESTING
//  1 ALU entry rd=5 pd_new=40 pd_old=5, free_ready=1 -> commit_ready=1, free_pd=5, ARAT[5]=40,
//    retired_cnt=1.
//  2 Same entry, free_ready=0 for 3 cycles -> commit_ready=0 until free_ready=1;
//    exactly one free beat; ARAT unchanged before the fire.
//  3 Store at head, st_commit_ready low 2 cycles -> st_commit_valid held, idx stable;
//    retires on cycle 3; no free beat.
//  4 flush_req while head retirable -> head not retired; flush_ack, then flush_valid 1 cycle later;
//    31 restore beats arch 1..31 with ARAT values; restore_done; back to RUN.
//  5 rst asserted at restore beat 10 -> all outputs 0 at once; ARAT identity; retired_cnt=0.
//  6 Back-to-back: 100 random commits with random free_ready/st_commit_ready -> ARAT matches
//    reference model; free count equals uses_rd & rd!=0 count.

Source files
------------

// File: rtl/commit_unit_pkg.sv
// Shared types and constants for the commit unit slice.
package commit_unit_pkg;

   localparam int unsigned ARCH_REGS = 32;
   localparam int unsigned AREG_W    = $clog2(ARCH_REGS);
   localparam int unsigned PHYS_W    = 6;
   localparam int unsigned ROB_W     = 5;

   typedef struct packed {
      logic              uses_rd;
      logic [AREG_W-1:0] rd_arch;
      logic [PHYS_W-1:0] pd_new;
      logic [PHYS_W-1:0] pd_old;
      logic              is_store;
   } rob_entry_t;

   typedef enum logic [1:0] {
      C_RUN,
      C_FLUSH,
      C_RESTORE
   } commit_state_t;

   // An entry frees pd_old and remaps the ARAT only when it writes a real register.
   function automatic logic entry_needs_free(input rob_entry_t e);
      return e.uses_rd && (e.rd_arch != '0);
   endfunction

endpackage

// File: rtl/commit_unit_if.sv
// Commit-side bus: ROB head handshake, free list release, store release,
// flush request/notify, ARAT replay and ARAT debug lookup.
interface commit_unit_if
   import commit_unit_pkg::*;
#(
   parameter int unsigned PHYS_W_P = PHYS_W,
   parameter int unsigned ROB_W_P  = ROB_W
) ();

   logic                commit_valid;
   logic                commit_ready;
   rob_entry_t          commit_entry;
   logic [ROB_W_P-1:0]  commit_rob_idx;

   logic                free_valid;
   logic                free_ready;
   logic [PHYS_W_P-1:0] free_pd;

   logic                st_commit_valid;
   logic                st_commit_ready;
   logic [ROB_W_P-1:0]  st_commit_rob_idx;

   logic                flush_req;
   logic                flush_ack;
   logic                flush_valid;
   logic [ROB_W_P-1:0]  flush_rob_idx;

   logic                restore_valid;
   logic [AREG_W-1:0]   restore_arch;
   logic [PHYS_W_P-1:0] restore_pd;
   logic                restore_done;

   logic [AREG_W-1:0]   rat_dbg_arch;
   logic [PHYS_W_P-1:0] rat_dbg_pd;

   // Commit unit side.
   modport slave (
      input  commit_valid, commit_entry, commit_rob_idx, free_ready, st_commit_ready,
             flush_req, rat_dbg_arch,
      output commit_ready, free_valid, free_pd, st_commit_valid, st_commit_rob_idx,
             flush_ack, flush_valid, flush_rob_idx, restore_valid, restore_arch,
             restore_pd, restore_done, rat_dbg_pd
   );

   // ROB / free list / LSQ / rename side.
   modport master (
      output commit_valid, commit_entry, commit_rob_idx, free_ready, st_commit_ready,
             flush_req, rat_dbg_arch,
      input  commit_ready, free_valid, free_pd, st_commit_valid, st_commit_rob_idx,
             flush_ack, flush_valid, flush_rob_idx, restore_valid, restore_arch,
             restore_pd, restore_done, rat_dbg_pd
   );

endinterface

// File: rtl/commit_unit_arch_rat.sv
// Architectural RAT: one write port, two combinational read ports, identity on reset.
module arch_rat
   import commit_unit_pkg::*;
#(
   parameter int unsigned PHYS_W_P = PHYS_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [AREG_W-1:0]   waddr,
   input  logic [PHYS_W_P-1:0] wdata,
   input  logic [AREG_W-1:0]   raddr_a,
   output logic [PHYS_W_P-1:0] rdata_a,
   input  logic [AREG_W-1:0]   raddr_b,
   output logic [PHYS_W_P-1:0] rdata_b
);

   logic [PHYS_W_P-1:0] map_q [ARCH_REGS];
   logic [PHYS_W_P-1:0] map_d [ARCH_REGS];

   // Apply the single write; x0 stays hard-wired to its identity mapping.
   always_comb begin
      map_d = map_q;
      if (we && (waddr != '0)) begin
         map_d[waddr] = wdata;
      end
   end

   // Mapping storage, identity after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < ARCH_REGS; i++) begin
            map_q[i] <= PHYS_W_P'(i);
         end
      end else begin
         map_q <= map_d;
      end
   end

   assign rdata_a = map_q[raddr_a];
   assign rdata_b = map_q[raddr_b];

endmodule

// File: rtl/commit_unit.sv
// In-order retirement of the ROB head, ARAT ownership, flush and ARAT replay.
module commit_unit
   import commit_unit_pkg::*;
#(
   parameter int unsigned PHYS_W_P = PHYS_W,
   parameter int unsigned ROB_W_P  = ROB_W,
   parameter int unsigned CNT_W    = 64
) (
   input  logic             clk,
   input  logic             rst,
   commit_unit_if.slave     cu,
   output logic [CNT_W-1:0] retired_cnt
);

   // One extra bit lets the counter reach ARCH_REGS, the done cycle after the last beat.
   localparam int unsigned CTR_W = AREG_W + 1;

   commit_state_t       state_q, state_d;
   logic [CTR_W-1:0]    ctr_q, ctr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ROB_W_P-1:0]  fidx_q, fidx_d;
   logic                needs_free;
   logic                commit_fire;
   logic [PHYS_W_P-1:0] replay_pd;

   assign needs_free  = entry_needs_free(cu.commit_entry);
   assign commit_fire = cu.commit_valid && cu.commit_ready;

   arch_rat #(.PHYS_W_P(PHYS_W_P)) u_arat (
      .clk     (clk),
      .rst     (rst),
      .we      (commit_fire && needs_free),
      .waddr   (cu.commit_entry.rd_arch),
      .wdata   (PHYS_W_P'(cu.commit_entry.pd_new)),
      .raddr_a (cu.rat_dbg_arch),
      .rdata_a (cu.rat_dbg_pd),
      .raddr_b (ctr_q[AREG_W-1:0]),
      .rdata_b (replay_pd)
   );

   // FSM state and replay counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= C_RUN;
         ctr_q   <= '0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
      end
   end

   // Next state: flush request wins in RUN; replay walks arch regs 1..ARCH_REGS-1.
   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      unique case (state_q)
         C_RUN: begin
            if (cu.flush_req) state_d = C_FLUSH;
         end
         C_FLUSH: begin
            state_d = C_RESTORE;
            ctr_d   = CTR_W'(1);
         end
         C_RESTORE: begin
            if (ctr_q == CTR_W'(ARCH_REGS)) state_d = C_RUN;
            else                            ctr_d   = ctr_q + CTR_W'(1);
         end
         default: state_d = C_RUN;
      endcase
   end

   // Outputs: handshakes only in RUN, and nothing is offered while reset is held.
   always_comb begin
      cu.commit_ready    = 1'b0;
      cu.free_valid      = 1'b0;
      cu.st_commit_valid = 1'b0;
      cu.flush_ack       = 1'b0;
      cu.flush_valid     = 1'b0;
      cu.restore_valid   = 1'b0;
      cu.restore_done    = 1'b0;
      if (!rst) begin
         unique case (state_q)
            C_RUN: begin
               cu.commit_ready    = !cu.flush_req
                                    && (!needs_free || cu.free_ready)
                                    && (!cu.commit_entry.is_store || cu.st_commit_ready);
               cu.free_valid      = cu.commit_valid && needs_free;
               cu.st_commit_valid = cu.commit_valid && cu.commit_entry.is_store;
               cu.flush_ack       = cu.flush_req;
            end
            C_FLUSH: cu.flush_valid = 1'b1;
            C_RESTORE: begin
               if (ctr_q == CTR_W'(ARCH_REGS)) cu.restore_done  = 1'b1;
               else                            cu.restore_valid = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign cu.free_pd           = PHYS_W_P'(cu.commit_entry.pd_old);
   assign cu.st_commit_rob_idx = cu.commit_rob_idx;
   assign cu.restore_arch      = ctr_q[AREG_W-1:0];
   assign cu.restore_pd        = replay_pd;
   assign cu.flush_rob_idx     = fidx_q;
   assign retired_cnt          = cnt_q;

   // Retirement bookkeeping: count and remember the index of the last retired entry.
   always_comb begin
      cnt_d  = cnt_q;
      fidx_d = fidx_q;
      if (commit_fire) begin
         cnt_d  = cnt_q + CNT_W'(1);
         fidx_d = cu.commit_rob_idx;
      end
   end

   // Retirement bookkeeping register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         fidx_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         fidx_q <= fidx_d;
      end
   end

endmodule

// File: tb/tb_commit_unit.sv
// Scoreboard bench for commit_unit: directed retire/stall/store/flush/reset cases
// followed by random back-to-back commits against a reference ARAT.
module tb_commit_unit;
   import commit_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] retired_cnt;

   always #5 clk = ~clk;

   commit_unit_if cu_if ();

   commit_unit #(.PHYS_W_P(PHYS_W), .ROB_W_P(ROB_W), .CNT_W(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .cu          (cu_if),
      .retired_cnt (retired_cnt)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned free_beats = 0;
   int unsigned exp_frees = 0;

   logic [PHYS_W-1:0]        exp_free_q [$];
   logic [ROB_W-1:0]         exp_st_q   [$];
   logic [AREG_W+PHYS_W-1:0] exp_rst_q  [$];

   logic [PHYS_W-1:0] ref_rat [ARCH_REGS];
   logic [63:0]       ref_cnt;

   rob_entry_t       re;
   logic [ROB_W-1:0] ridx;
   logic             fr, sr, nf, exp_rdy, fired;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic model_reset();
      for (int i = 0; i < ARCH_REGS; i++) ref_rat[i] = PHYS_W'(i);
      ref_cnt = '0;
   endtask

   task automatic drive_entry(input logic u, input int rd, input int pn, input int po,
                              input logic st, input int idx);
      cu_if.commit_valid          = 1'b1;
      cu_if.commit_entry.uses_rd  = u;
      cu_if.commit_entry.rd_arch  = AREG_W'(rd);
      cu_if.commit_entry.pd_new   = PHYS_W'(pn);
      cu_if.commit_entry.pd_old   = PHYS_W'(po);
      cu_if.commit_entry.is_store = st;
      cu_if.commit_rob_idx        = ROB_W'(idx);
   endtask

   task automatic push_replay();
      for (int i = 1; i < ARCH_REGS; i++) exp_rst_q.push_back({AREG_W'(i), ref_rat[i]});
   endtask

   // Scoreboard: pop expectations as the DUT produces handshakes and replay beats.
   always @(negedge clk) begin
      if (!rst) begin
         if (cu_if.free_valid && cu_if.free_ready && cu_if.commit_ready) begin
            free_beats++;
            if (exp_free_q.size() == 0) chk("free_unexpected", 64'(exp_free_q.size()), 64'd1);
            else                        chk("free_pd", 64'(cu_if.free_pd), 64'(exp_free_q.pop_front()));
         end
         if (cu_if.st_commit_valid && cu_if.st_commit_ready && cu_if.commit_ready) begin
            if (exp_st_q.size() == 0) chk("st_unexpected", 64'(exp_st_q.size()), 64'd1);
            else                      chk("st_idx", 64'(cu_if.st_commit_rob_idx), 64'(exp_st_q.pop_front()));
         end
         if (cu_if.restore_valid) begin
            if (exp_rst_q.size() == 0) chk("restore_unexpected", 64'(exp_rst_q.size()), 64'd1);
            else chk("restore_beat", 64'({cu_if.restore_arch, cu_if.restore_pd}),
                     64'(exp_rst_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      cu_if.commit_valid    = 1'b0;
      cu_if.commit_entry    = '0;
      cu_if.commit_rob_idx  = '0;
      cu_if.free_ready      = 1'b0;
      cu_if.st_commit_ready = 1'b0;
      cu_if.flush_req       = 1'b0;
      cu_if.rat_dbg_arch    = AREG_W'(7);
      model_reset();

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_cnt", retired_cnt, 64'd0);
      chk("rst_fidx", 64'(cu_if.flush_rob_idx), 64'd0);
      chk("rst_outs", 64'({cu_if.free_valid, cu_if.st_commit_valid, cu_if.flush_ack,
                           cu_if.flush_valid, cu_if.restore_valid, cu_if.restore_done}), 64'd0);
      chk("rst_arat7", 64'(cu_if.rat_dbg_pd), 64'd7);
      tick();
      rst = 1'b0;
      cu_if.rat_dbg_arch = AREG_W'(5);

      // 1: ALU entry rd=5 pd_new=40 pd_old=5
      drive_entry(1'b1, 5, 40, 5, 1'b0, 3);
      cu_if.free_ready = 1'b1;
      exp_free_q.push_back(PHYS_W'(5));
      @(negedge clk);
      chk("t1_ready", 64'(cu_if.commit_ready), 64'd1);
      chk("t1_free_valid", 64'(cu_if.free_valid), 64'd1);
      tick();
      ref_rat[5] = PHYS_W'(40); ref_cnt++;
      cu_if.commit_valid = 1'b0;
      @(negedge clk);
      chk("t1_cnt", retired_cnt, ref_cnt);
      chk("t1_arat5", 64'(cu_if.rat_dbg_pd), 64'd40);
      chk("t1_fidx", 64'(cu_if.flush_rob_idx), 64'd3);

      // 2: free list back-pressure for 3 cycles
      tick();
      drive_entry(1'b1, 5, 41, 40, 1'b0, 4);
      cu_if.free_ready = 1'b0;
      free_beats = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t2_stall_ready", 64'(cu_if.commit_ready), 64'd0);
         chk("t2_free_valid", 64'(cu_if.free_valid), 64'd1);
         chk("t2_arat5_hold", 64'(cu_if.rat_dbg_pd), 64'd40);
         tick();
      end
      cu_if.free_ready = 1'b1;
      exp_free_q.push_back(PHYS_W'(40));
      @(negedge clk);
      chk("t2_ready", 64'(cu_if.commit_ready), 64'd1);
      tick();
      ref_rat[5] = PHYS_W'(41); ref_cnt++;
      cu_if.commit_valid = 1'b0;
      @(negedge clk);
      chk("t2_arat5", 64'(cu_if.rat_dbg_pd), 64'd41);
      chk("t2_cnt", retired_cnt, ref_cnt);
      chk("t2_free_beats", 64'(free_beats), 64'd1);

      // 3: store with LSQ back-pressure for 2 cycles
      tick();
      drive_entry(1'b0, 0, 0, 0, 1'b1, 9);
      cu_if.free_ready = 1'b0;
      cu_if.st_commit_ready = 1'b0;
      free_beats = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("t3_st_valid", 64'(cu_if.st_commit_valid), 64'd1);
         chk("t3_st_idx", 64'(cu_if.st_commit_rob_idx), 64'd9);
         chk("t3_stall_ready", 64'(cu_if.commit_ready), 64'd0);
         tick();
      end
      cu_if.st_commit_ready = 1'b1;
      exp_st_q.push_back(ROB_W'(9));
      @(negedge clk);
      chk("t3_ready", 64'(cu_if.commit_ready), 64'd1);
      chk("t3_no_free", 64'(cu_if.free_valid), 64'd0);
      tick();
      ref_cnt++;
      cu_if.commit_valid = 1'b0;
      cu_if.st_commit_ready = 1'b0;
      @(negedge clk);
      chk("t3_cnt", retired_cnt, ref_cnt);
      chk("t3_free_beats", 64'(free_beats), 64'd0);

      // 4: flush while head retirable, then full ARAT replay
      tick();
      drive_entry(1'b1, 6, 50, 6, 1'b0, 12);
      cu_if.free_ready = 1'b1;
      cu_if.flush_req = 1'b1;
      @(negedge clk);
      chk("t4_ready", 64'(cu_if.commit_ready), 64'd0);
      chk("t4_ack", 64'(cu_if.flush_ack), 64'd1);
      chk("t4_fv_early", 64'(cu_if.flush_valid), 64'd0);
      tick();
      cu_if.flush_req = 1'b0;
      cu_if.commit_valid = 1'b0;
      push_replay();
      @(negedge clk);
      chk("t4_flush_valid", 64'(cu_if.flush_valid), 64'd1);
      chk("t4_flush_idx", 64'(cu_if.flush_rob_idx), 64'd9);
      chk("t4_ack_gone", 64'(cu_if.flush_ack), 64'd0);
      for (int b = 1; b < ARCH_REGS; b++) begin
         tick();
         cu_if.flush_req = (b >= 20 && b <= 22);
         @(negedge clk);
         chk("t4_beat_valid", 64'(cu_if.restore_valid), 64'd1);
         chk("t4_beat_ack", 64'(cu_if.flush_ack), 64'd0);
         chk("t4_beat_ready", 64'(cu_if.commit_ready), 64'd0);
      end
      tick();
      cu_if.flush_req = 1'b0;
      @(negedge clk);
      chk("t4_done", 64'(cu_if.restore_done), 64'd1);
      chk("t4_done_nobeat", 64'(cu_if.restore_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("t4_done_pulse", 64'(cu_if.restore_done), 64'd0);
      chk("t4_run_ready", 64'(cu_if.commit_ready), 64'd1);
      chk("t4_cnt", retired_cnt, ref_cnt);
      chk("t4_replay_left", 64'(exp_rst_q.size()), 64'd0);
      cu_if.rat_dbg_arch = AREG_W'(6);
      #1 chk("t4_arat6", 64'(cu_if.rat_dbg_pd), 64'd6);

      // 5: reset at replay beat 10
      tick();
      cu_if.rat_dbg_arch = AREG_W'(5);
      cu_if.flush_req = 1'b1;
      tick();
      cu_if.flush_req = 1'b0;
      push_replay();
      for (int b = 1; b <= 10; b++) tick();
      @(negedge clk);
      chk("t5_beat10", 64'(cu_if.restore_arch), 64'd10);
      #1 rst = 1'b1;
      #1;
      chk("t5_rv", 64'(cu_if.restore_valid), 64'd0);
      chk("t5_outs", 64'({cu_if.restore_done, cu_if.flush_valid, cu_if.flush_ack,
                          cu_if.free_valid, cu_if.st_commit_valid, cu_if.commit_ready}), 64'd0);
      chk("t5_cnt", retired_cnt, 64'd0);
      chk("t5_fidx", 64'(cu_if.flush_rob_idx), 64'd0);
      chk("t5_arat5", 64'(cu_if.rat_dbg_pd), 64'd5);
      exp_rst_q.delete();
      model_reset();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t5_no_beat", 64'(cu_if.restore_valid), 64'd0);
         chk("t5_run_ready", 64'(cu_if.commit_ready), 64'd1);
         tick();
      end

      // 6: random back-to-back commits
      free_beats = 0;
      exp_frees = 0;
      for (int k = 0; k < 100; k++) begin
         re.uses_rd  = ($urandom_range(0, 3) != 0);
         re.rd_arch  = AREG_W'($urandom_range(0, ARCH_REGS - 1));
         re.pd_new   = PHYS_W'($urandom);
         re.pd_old   = PHYS_W'($urandom);
         re.is_store = ($urandom_range(0, 3) == 0);
         ridx        = ROB_W'($urandom);
         cu_if.commit_valid   = 1'b1;
         cu_if.commit_entry   = re;
         cu_if.commit_rob_idx = ridx;
         nf = re.uses_rd && (re.rd_arch != '0);
         fired = 1'b0;
         for (int t = 0; t < 16 && !fired; t++) begin
            fr = (t >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            sr = (t >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            cu_if.free_ready      = fr;
            cu_if.st_commit_ready = sr;
            exp_rdy = (!nf || fr) && (!re.is_store || sr);
            if (exp_rdy && nf)          exp_free_q.push_back(re.pd_old);
            if (exp_rdy && re.is_store) exp_st_q.push_back(ridx);
            @(negedge clk);
            chk("t6_ready", 64'(cu_if.commit_ready), 64'(exp_rdy));
            tick();
            if (exp_rdy) begin
               fired = 1'b1;
               ref_cnt++;
               if (nf) begin
                  ref_rat[re.rd_arch] = re.pd_new;
                  exp_frees++;
               end
            end
         end
         chk("t6_fired", 64'(fired), 64'd1);
      end
      cu_if.commit_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < ARCH_REGS; i++) begin
         cu_if.rat_dbg_arch = AREG_W'(i);
         #1 chk("t6_arat", 64'(cu_if.rat_dbg_pd), 64'(ref_rat[i]));
      end
      chk("t6_cnt", retired_cnt, ref_cnt);
      chk("t6_free_count", 64'(free_beats), 64'(exp_frees));
      chk("t6_free_left", 64'(exp_free_q.size()), 64'd0);
      chk("t6_st_left", 64'(exp_st_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
